// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped table of 2-bit saturating counters. Guesses taken/not-taken
//   for the FD-stage branch, trains on the X-stage resolution, flags
//   mispredicts back to control and keeps branch/mispredict statistics.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   pc_guess, is_br_guess      FD-stage PC and "is a branch" qualifier
//   br_pred                    combinational guess for pc_guess (1 = taken)
//   pc_check, is_br_check      X-stage PC and "resolution valid" qualifier
//   br_taken_check             actual X-stage outcome
//   mispredict                 combinational: X outcome != recorded guess
//   stats_clr                  synchronous clear of both statistic counters
//   br_count                   resolved branches since reset/clear
//   mispredict_count           mispredicted branches since reset/clear
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int PC_WIDTH = 32,
  parameter int IDX_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] pc_guess,
  input  logic                is_br_guess,
  output logic                br_pred,
  input  logic [PC_WIDTH-1:0] pc_check,
  input  logic                is_br_check,
  input  logic                br_taken_check,
  output logic                mispredict,
  input  logic                stats_clr,
  output logic [31:0]         br_count,
  output logic [31:0]         mispredict_count
);

  localparam int LINES = 1 << IDX_BITS;
  localparam int TAG_W = PC_WIDTH - 2 - IDX_BITS;

  // Prediction table
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];
  logic [1:0]       r_ctr [LINES];

  // Guess recorded in FD, compared when the same instruction reaches X
  logic r_pred_q;
  logic r_pred_v;

  logic [31:0] r_br_count;
  logic [31:0] r_mp_count;

  // Lookup side
  logic [IDX_BITS-1:0] w_g_idx;
  logic [TAG_W-1:0]    w_g_tag;
  logic                w_g_hit;

  // Update side
  logic [IDX_BITS-1:0] w_c_idx;
  logic [TAG_W-1:0]    w_c_tag;
  logic                w_c_hit;
  logic [1:0]          w_ctr_cur;
  logic [1:0]          w_ctr_next;
  logic                w_mispredict;

  // Byte offset bits of both PCs are intentionally ignored
  logic w_unused;
  assign w_unused = &{1'b0, pc_guess[1:0], pc_check[1:0]};

  assign w_g_idx = pc_guess[IDX_BITS+1:2];
  assign w_g_tag = pc_guess[PC_WIDTH-1:IDX_BITS+2];
  assign w_c_idx = pc_check[IDX_BITS+1:2];
  assign w_c_tag = pc_check[PC_WIDTH-1:IDX_BITS+2];

  // Reads pre-edge table state only; a same-cycle update is not bypassed
  assign w_g_hit = r_valid[w_g_idx] && (r_tag[w_g_idx] == w_g_tag);
  assign br_pred = is_br_guess && w_g_hit && r_ctr[w_g_idx][1];

  // A check with no recorded guess compares against not-taken
  assign w_mispredict = is_br_check && (br_taken_check != (r_pred_v && r_pred_q));
  assign mispredict   = w_mispredict;

  assign w_c_hit   = r_valid[w_c_idx] && (r_tag[w_c_idx] == w_c_tag);
  assign w_ctr_cur = r_ctr[w_c_idx];

  always_comb begin
    w_ctr_next = '0;
    if (!w_c_hit) begin
      // Fresh allocation starts weakly biased toward the observed outcome
      w_ctr_next = br_taken_check ? 2'b10 : 2'b01;
    end else if (br_taken_check) begin
      w_ctr_next = (w_ctr_cur == 2'b11) ? 2'b11 : w_ctr_cur + 2'd1;
    end else begin
      w_ctr_next = (w_ctr_cur == 2'b00) ? 2'b00 : w_ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_tag   <= '{default: '0};
      r_ctr   <= '{default: '0};
    end else if (is_br_check) begin
      r_valid[w_c_idx] <= 1'b1;
      r_tag[w_c_idx]   <= w_c_tag;
      r_ctr[w_c_idx]   <= w_ctr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_q <= 1'b0;
      r_pred_v <= 1'b0;
    end else begin
      r_pred_q <= br_pred;
      r_pred_v <= is_br_guess;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count <= '0;
      r_mp_count <= '0;
    end else if (stats_clr) begin
      r_br_count <= '0;
      r_mp_count <= '0;
    end else if (is_br_check) begin
      r_br_count <= r_br_count + 32'd1;
      if (w_mispredict) begin
        r_mp_count <= r_mp_count + 32'd1;
      end
    end
  end

  assign br_count         = r_br_count;
  assign mispredict_count = r_mp_count;

endmodule
